two_of_five_tx: RTL and testbench

- Serial transmitter for the 2-of-5 decimal code; the transmit end of the 2-of-5 nibble link.
- Accepts a decimal digit (0-9) over a valid/ready handshake and encodes it to its 5-bit 2-of-5 nibble.
- Shifts the nibble out one bit per clock, LSB first, so the receiver sees contiguous nibbles with no gap between frames.
- Also keeps a wrap-around count of transmitted nibbles and flags illegal digits.

---
 rtl/two_of_five_tx.sv | 128 ++++++++++++
 tb/tb_two_of_five_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/two_of_five_tx.sv
// two_of_five_tx
// Serial transmitter for the 2-of-5 decimal code. A digit (0-9) accepted on
// the valid/ready handshake is encoded into a 5-bit nibble with exactly two
// ones and shifted out LSB first, one bit per clock. Frames are contiguous:
// a digit accepted on the last-bit cycle starts immediately after it.
//
// Ports:
//   clk         rising-edge clock
//   reset_l     asynchronous active-low reset
//   digit_valid digit presented on digit
//   digit       decimal digit to send (10-15 are illegal and dropped)
//   digit_ready block accepts a digit this cycle (independent of digit_valid)
//   ser_out     serial data bit (IDLE_BIT when not transmitting)
//   ser_valid   ser_out carries a nibble bit this cycle
//   ser_last    ser_out is bit 4, the final bit of the nibble
//   digit_err   one-cycle pulse after an illegal digit was accepted
//   nib_count   count of fully transmitted nibbles, modulo 2^CNT_W
module two_of_five_tx #(
  parameter int   CNT_W    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic             digit_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             digit_err,
  output logic [CNT_W-1:0] nib_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [4:0]       shreg, shreg_nxt;
  logic [CNT_W-1:0] nib_cnt_r, nib_cnt_nxt;
  logic             err_r, err_nxt;
  logic             last_bit;
  logic             accept;
  logic             legal;

  // 2-of-5 code table, nibble written MSB..LSB.
  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] c;
    case (d)
      4'd0:    c = 5'b00011;
      4'd1:    c = 5'b00101;
      4'd2:    c = 5'b00110;
      4'd3:    c = 5'b01010;
      4'd4:    c = 5'b01100;
      4'd5:    c = 5'b01001;
      4'd6:    c = 5'b11000;
      4'd7:    c = 5'b10100;
      4'd8:    c = 5'b10010;
      4'd9:    c = 5'b10001;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

  assign last_bit    = (state == SHIFT) && (bit_cnt == 3'd4);
  // Ready on the last-bit cycle is what makes back-to-back frames gapless.
  assign digit_ready = (state == IDLE) || last_bit;
  assign accept      = digit_valid && digit_ready;
  assign legal       = (digit <= 4'd9);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    nib_cnt_nxt = nib_cnt_r;
    err_nxt     = accept && !legal;
    case (state)
      IDLE: begin
        if (accept && legal) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = 3'd0;
          shreg_nxt   = encode(digit);
        end
      end
      SHIFT: begin
        if (last_bit) begin
          nib_cnt_nxt = nib_cnt_r + 1'b1;
          if (accept && legal) begin
            bit_cnt_nxt = 3'd0;
            shreg_nxt   = encode(digit);
          end else begin
            // Includes the illegal-digit case: the current nibble still counts.
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            shreg_nxt   = 5'b00000;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          shreg_nxt   = {1'b0, shreg[4:1]};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 5'b00000;
      nib_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      nib_cnt_r <= nib_cnt_nxt;
      err_r     <= err_nxt;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? shreg[0] : IDLE_BIT;
  assign ser_last  = last_bit;
  assign digit_err = err_r;
  assign nib_count = nib_cnt_r;

endmodule

// File: tb/tb_two_of_five_tx.sv
// Testbench for two_of_five_tx: a queue-based model of the expected serial
// stream plus a loopback decoder that checks every received frame.
module tb_two_of_five_tx;

  localparam logic IDLE_BIT = 1'b0;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;

  logic       digit_ready, ser_out, ser_valid, ser_last, digit_err;
  logic [7:0] nib_count;
  logic       digit_ready3, ser_out3, ser_valid3, ser_last3, digit_err3;
  logic [2:0] nib_count3;

  two_of_five_tx #(.CNT_W(8), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .reset_l(reset_l), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(digit_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_last(ser_last), .digit_err(digit_err), .nib_count(nib_count)
  );

  two_of_five_tx #(.CNT_W(3), .IDLE_BIT(IDLE_BIT)) dut3 (
    .clk(clk), .reset_l(reset_l), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(digit_ready3), .ser_out(ser_out3), .ser_valid(ser_valid3),
    .ser_last(ser_last3), .digit_err(digit_err3), .nib_count(nib_count3)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Code table written MSB..LSB as in the digit table.
  localparam logic [4:0] CODES [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                                        5'b01001, 5'b11000, 5'b10100, 5'b10010, 5'b10001};

  function automatic int decode(input logic [4:0] f);
    for (int i = 0; i < 10; i++) if (CODES[i] == f) return i;
    return 15;
  endfunction

  // Model: expected bits still to appear on ser_out, one entry per cycle.
  bit         exp_bits[$];
  bit         exp_last[$];
  int         rx_q[$];
  int         send_q[$];
  int         exp_cnt = 0;
  bit         exp_err = 1'b0;
  bit         hold = 1'b1;
  logic [4:0] obs = 5'b0;
  int         obs_n = 0;

  task automatic cycle();
    bit         accept;
    logic [4:0] c;
    int         want;
    @(negedge clk);
    if (send_q.size() > 0 && (hold || $urandom_range(3) != 0)) begin
      digit_valid = 1'b1;
      digit       = 4'(send_q[0]);
    end else begin
      digit_valid = 1'b0;
      digit       = 4'($urandom_range(15));
    end
    #1;
    check("ready",  digit_ready, 32'(exp_bits.size() <= 1));
    check("valid",  ser_valid,   32'(exp_bits.size() > 0));
    check("out",    ser_out,     32'((exp_bits.size() > 0) ? exp_bits[0] : IDLE_BIT));
    check("last",   ser_last,    32'((exp_bits.size() > 0) && exp_last[0]));
    check("err",    digit_err,   32'(exp_err));
    check("cnt",    nib_count,   32'(exp_cnt % 256));
    check("cnt3",   nib_count3,  32'(exp_cnt % 8));
    check("valid3", ser_valid3,  32'(exp_bits.size() > 0));
    // Loopback receiver on the observed stream.
    if (ser_valid) begin
      if (obs_n < 5) obs[obs_n] = ser_out;
      obs_n++;
      if (ser_last) begin
        want = (rx_q.size() > 0) ? rx_q.pop_front() : 99;
        check("frame_len", 32'(obs_n), 32'd5);
        check("ones",      32'($countones(obs)), 32'd2);
        check("decode",    32'(decode(obs)), 32'(want));
        obs   = 5'b0;
        obs_n = 0;
      end
    end
    // Advance the model to what the next rising edge produces.
    accept = digit_valid && (exp_bits.size() <= 1);
    if (exp_bits.size() > 0) begin
      if (exp_last[0]) exp_cnt++;
      void'(exp_bits.pop_front());
      void'(exp_last.pop_front());
    end
    exp_err = accept && (digit > 4'd9);
    if (accept) begin
      void'(send_q.pop_front());
      if (digit <= 4'd9) begin
        c = CODES[digit];
        for (int i = 0; i < 5; i++) begin
          exp_bits.push_back(c[i]);
          exp_last.push_back(i == 4);
        end
        rx_q.push_back(int'(digit));
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || exp_bits.size() > 0 || exp_err) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'd0, 32'd1);
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    reset_l = 1'b0;
    digit_valid = 1'b0;
    #1;
    check("rst_valid", ser_valid,   32'd0);
    check("rst_out",   ser_out,     32'(IDLE_BIT));
    check("rst_last",  ser_last,    32'd0);
    check("rst_err",   digit_err,   32'd0);
    check("rst_cnt",   nib_count,   32'd0);
    check("rst_cnt3",  nib_count3,  32'd0);
    check("rst_ready", digit_ready, 32'd1);
    exp_bits.delete();
    exp_last.delete();
    rx_q.delete();
    send_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    obs     = 5'b0;
    obs_n   = 0;
    @(posedge clk);
    #2 reset_l = 1'b1;
  endtask

  initial begin
    int n;
    // Reset values, with a clock edge under reset.
    reset_l = 1'b0;
    repeat (2) @(posedge clk);
    #2 apply_reset();

    // Single digit 0.
    hold = 1'b1;
    send_q.push_back(0);
    run_until_idle(50);

    // Stream 0..9 with valid held: contiguous frames, 3-bit count wraps.
    for (int d = 0; d < 10; d++) send_q.push_back(d);
    run_until_idle(100);
    check("stream_cnt", nib_count, 32'd11);

    // Illegal digit from idle, then a legal one.
    send_q.push_back(12);
    send_q.push_back(7);
    run_until_idle(50);

    // Illegal digit offered on the last-bit cycle of a frame.
    send_q.push_back(3);
    send_q.push_back(15);
    run_until_idle(50);

    // Reset during bit 2 of digit 6.
    send_q.push_back(6);
    n = 0;
    while (exp_bits.size() != 3 && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) check("wait_bit2", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    check("mid_valid", ser_valid, 32'd1);
    apply_reset();
    send_q.push_back(9);
    run_until_idle(50);

    // Random digits including illegal ones, random valid gaps.
    hold = 1'b0;
    for (int i = 0; i < 150; i++) send_q.push_back(int'($urandom_range(15)));
    run_until_idle(3000);

    // Random digits with valid held for back-to-back frames.
    hold = 1'b1;
    for (int i = 0; i < 60; i++) send_q.push_back(int'($urandom_range(15)));
    run_until_idle(1000);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
